// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts out one command byte plus parity and stop bit on the device's clock.
// Latency: ps2_clk held low for INHIBIT_CYCLES after accept, then one bit per device clock; a device falling edge moves ps2_data_oe 3 clk cycles later.
// Backpressure: tx_ready is high only in IDLE; tx_valid is ignored while a transfer is in flight.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES       = 10_000,
  parameter int unsigned START_TIMEOUT_CYCLES = 1_500_000,
  parameter int unsigned BIT_TIMEOUT_CYCLES   = 200_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] tx_err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // Timer limits expressed as the last count before the event fires,
  // so an event happens exactly N cycles after the timer was cleared.
  localparam logic [20:0] INH_LAST   = 21'(INHIBIT_CYCLES - 1);
  localparam logic [20:0] START_LAST = 21'(START_TIMEOUT_CYCLES - 1);
  localparam logic [20:0] BIT_LAST   = 21'(BIT_TIMEOUT_CYCLES - 1);
  localparam logic [20:0] TIMER_MAX  = '1;

  localparam logic [1:0] ERR_NACK      = 2'd1;
  localparam logic [1:0] ERR_START_TO  = 2'd2;
  localparam logic [1:0] ERR_BIT_TO    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_DATA,
    S_WAIT_IDLE
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  shift_q, shift_d;      // {parity, data}, LSB goes out next
  logic [3:0]  bit_cnt_q, bit_cnt_d;  // device falling edges seen so far
  logic [20:0] timer_q, timer_d;
  logic        clk_oe_q, clk_oe_d;
  logic        data_oe_q, data_oe_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [1:0]  err_code_q, err_code_d;

  // Two-flop synchronisers plus one history flop for clock edge detection.
  logic        clk_meta_q, clk_meta_d;
  logic        clk_sync_q, clk_sync_d;
  logic        clk_prev_q, clk_prev_d;
  logic        data_meta_q, data_meta_d;
  logic        data_sync_q, data_sync_d;

  logic        fall;
  logic [20:0] timer_inc;

  assign fall      = clk_prev_q & ~clk_sync_q;
  assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + 21'd1;

  // Next-state, datapath and output decode for the transfer sequence.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    timer_d     = timer_inc;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    err_code_d  = err_code_q;
    clk_meta_d  = ps2_clk_in;
    clk_sync_d  = clk_meta_q;
    clk_prev_d  = clk_sync_q;
    data_meta_d = ps2_data_in;
    data_sync_d = data_meta_q;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (tx_valid) begin
          // Odd parity: the parity bit makes the total count of ones odd.
          shift_d   = {~^tx_data, tx_data};
          bit_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (timer_q >= INH_LAST) begin
          // Request-to-send: release clock, pull data low as the start bit.
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          timer_d   = '0;
          state_d   = S_RTS;
        end
      end

      S_RTS: begin
        if (fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[8:1]};
          bit_cnt_d = 4'd1;
          timer_d   = '0;
          state_d   = S_DATA;
        end else if (timer_q >= START_LAST) begin
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b0;
          error_d    = 1'b1;
          err_code_d = ERR_START_TO;
          timer_d    = '0;
          state_d    = S_IDLE;
        end
      end

      S_DATA: begin
        if (fall) begin
          timer_d   = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q <= 4'd8) begin
            // Falls 2..9: remaining data bits then parity.
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
          end else if (bit_cnt_q == 4'd9) begin
            // Fall 10: stop bit, line released.
            data_oe_d = 1'b0;
          end else if (!data_sync_q) begin
            // Fall 11: device holds data low to acknowledge.
            state_d = S_WAIT_IDLE;
          end else begin
            clk_oe_d   = 1'b0;
            data_oe_d  = 1'b0;
            error_d    = 1'b1;
            err_code_d = ERR_NACK;
            timer_d    = '0;
            state_d    = S_IDLE;
          end
        end else if (timer_q >= BIT_LAST) begin
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b0;
          error_d    = 1'b1;
          err_code_d = ERR_BIT_TO;
          timer_d    = '0;
          state_d    = S_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        if (clk_sync_q && data_sync_q) begin
          done_d  = 1'b1;
          timer_d = '0;
          state_d = S_IDLE;
        end else if (timer_q >= BIT_LAST) begin
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b0;
          error_d    = 1'b1;
          err_code_d = ERR_BIT_TO;
          timer_d    = '0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        timer_d   = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronisers reset to the idle-high bus level.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      timer_q     <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= '0;
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      timer_q     <= timer_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      clk_prev_q  <= clk_prev_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign tx_busy     = (state_q != S_IDLE);
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign tx_err_code = err_code_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus model, PS/2 device model and per-transfer checks against a byte/parity reference.
// Latency: uses shortened inhibit/timeout parameters so every scenario completes in a few hundred cycles.
// Backpressure: drives tx_valid only after checking tx_ready, except the deliberate busy-time request.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int STO = 300;
  localparam int BTO = 100;
  localparam int H   = 8;    // device clock half period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic [1:0] tx_err_code;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_pin, ps2_data_pin;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int clk_run = 0, last_run = 0;
  int rts_cyc = 0, err_cyc = 0, fall_cyc = 0;
  logic clk_oe_prev = 1'b0;

  // Wired-AND open-drain bus with pull-ups.
  assign ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_pin = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES      (INH),
    .START_TIMEOUT_CYCLES(STO),
    .BIT_TIMEOUT_CYCLES  (BTO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .tx_err_code(tx_err_code),
    .ps2_clk_in (ps2_clk_pin),
    .ps2_data_in(ps2_data_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  // Free-running cycle count for timing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters, RTS timestamp and clock-inhibit run length.
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (tx_done && tx_error) both_cnt++;
    if (ps2_data_oe && clk_oe_prev && !ps2_clk_oe) rts_cyc = cyc;
    clk_oe_prev = ps2_clk_oe;
    if (ps2_clk_oe) clk_run++;
    else if (clk_run != 0) begin
      last_run = clk_run;
      clk_run  = 0;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: odd parity bit = 1 when the byte has an even number of ones.
  function automatic int odd_par(input logic [7:0] b);
    return (($countones(b) % 2) == 0) ? 1 : 0;
  endfunction

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rts(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < INH + 20; k++) begin
      if (ps2_clk_pin && !ps2_data_pin) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  // Device clocks nfalls edges; bits[i-1] is the line level sampled while low after fall i.
  task automatic dev_clock(input int nfalls, input bit ack, output logic [9:0] bits);
    bits = '0;
    step(3);
    for (int i = 1; i <= nfalls; i++) begin
      if (i == 11 && ack) begin
        dev_data_low = 1'b1;
        step(H / 2);
      end
      dev_clk_low = 1'b1;
      fall_cyc = cyc;
      step(H);
      if (i <= 10) bits[i-1] = ps2_data_pin;
      dev_clk_low = 1'b0;
      step(H);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] b, input bit ack, input bit intrude);
    int d0, e0;
    bit ok;
    logic [9:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    chk({tag, "_ready_before"}, int'(tx_ready), 1);
    send(b);
    if (intrude) begin
      step(3);
      tx_data  = 8'hAA;
      tx_valid = 1'b1;
      step(1);
      chk({tag, "_ready_while_busy"}, int'(tx_ready), 0);
      tx_valid = 1'b0;
      tx_data  = 8'h00;
    end
    wait_rts(ok);
    chk({tag, "_rts_seen"}, int'(ok), 1);
    dev_clock(11, ack, bits);
    chk({tag, "_inhibit_len"}, last_run, INH);
    chk({tag, "_data_bits"}, int'(bits[7:0]), int'(b));
    chk({tag, "_parity"}, int'(bits[8]), odd_par(b));
    chk({tag, "_stop"}, int'(bits[9]), 1);
    for (int k = 0; k < 40 && done_cnt == d0 && err_cnt == e0; k++) step(1);
    step(2);
    if (ack) begin
      chk({tag, "_done_pulses"}, done_cnt - d0, 1);
      chk({tag, "_no_error"}, err_cnt - e0, 0);
    end else begin
      chk({tag, "_error_pulses"}, err_cnt - e0, 1);
      chk({tag, "_err_code"}, int'(tx_err_code), 1);
      chk({tag, "_no_done"}, done_cnt - d0, 0);
    end
    chk({tag, "_ready_after"}, int'(tx_ready), 1);
    chk({tag, "_oe_released"}, int'({ps2_clk_oe, ps2_data_oe}), 0);
  endtask

  initial begin
    bit ok;
    logic [9:0] bits;
    int d0, e0;
    logic [7:0] rb;
    bit rack;

    // Reset state
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_busy", int'(tx_busy), 0);
    chk("rst_oe", int'({ps2_clk_oe, ps2_data_oe}), 0);
    chk("rst_pulses", int'({tx_done, tx_error}), 0);
    chk("rst_code", int'(tx_err_code), 0);
    step(2);

    // 1: 0xED acknowledged
    run_xfer("t1", 8'hED, 1'b1, 1'b0);

    // 2: 0x00 NACKed
    run_xfer("t2", 8'h00, 1'b0, 1'b0);

    // 3: device never clocks after RTS
    e0 = err_cnt;
    send(8'h12);
    wait_rts(ok);
    chk("t3_rts_seen", int'(ok), 1);
    for (int k = 0; k < STO + 40 && err_cnt == e0; k++) step(1);
    step(1);
    chk("t3_error_pulses", err_cnt - e0, 1);
    chk("t3_err_code", int'(tx_err_code), 2);
    chk("t3_timeout_len", err_cyc - rts_cyc, STO);
    chk("t3_oe_released", int'({ps2_clk_oe, ps2_data_oe}), 0);

    // 4: device stops after 4 falls
    e0 = err_cnt;
    d0 = done_cnt;
    send(8'h3C);
    wait_rts(ok);
    dev_clock(4, 1'b0, bits);
    chk("t4_first_bits", int'(bits[3:0]), int'(4'hC));
    for (int k = 0; k < BTO + 40 && err_cnt == e0; k++) step(1);
    step(1);
    chk("t4_error_pulses", err_cnt - e0, 1);
    chk("t4_err_code", int'(tx_err_code), 3);
    chk("t4_timeout_window", int'((err_cyc - fall_cyc >= BTO) && (err_cyc - fall_cyc <= BTO + 5)), 1);
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_oe_released", int'({ps2_clk_oe, ps2_data_oe}), 0);

    // 5: reset during fall 5 of 0xFF, then 0xF4 completes
    e0 = err_cnt;
    d0 = done_cnt;
    send(8'hFF);
    wait_rts(ok);
    dev_clock(4, 1'b0, bits);
    dev_clk_low = 1'b1;
    step(4);
    reset = 1'b1;
    step(1);
    chk("t5_oe_after_reset", int'({ps2_clk_oe, ps2_data_oe}), 0);
    reset = 1'b0;
    dev_clk_low = 1'b0;
    step(3);
    chk("t5_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    chk("t5_code_cleared", int'(tx_err_code), 0);
    chk("t5_idle", int'(tx_ready), 1);
    run_xfer("t5b", 8'hF4, 1'b1, 1'b0);

    // 6: 0xAA requested while busy with 0x55
    run_xfer("t6", 8'h55, 1'b1, 1'b1);
    step(INH);
    chk("t6_no_second_xfer", int'({tx_ready, ps2_clk_oe}), 2);

    // Randomised bytes and ACK/NACK outcomes
    for (int t = 0; t < 6; t++) begin
      rb   = 8'($urandom_range(0, 255));
      rack = ($urandom_range(0, 3) != 0);
      run_xfer($sformatf("rnd%0d", t), rb, rack, 1'b0);
    end

    chk("never_done_and_error", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
